regfile_scoreboard: RTL and testbench

Parametrised integer architectural register file with per-register pending-write scoreboard, N read ports, one write-back port and one claim (invalidation) port. Sits between decode and execute/write-back; generates the stall that freezes fetch and decode. Extends the current single-bit valid scheme with multi-outstanding-write counters, optional write-back bypass, a claim-full stall and pipeline-flush recovery.

---
 rtl/regfile_scoreboard_pkg.sv | 17 +
 rtl/regfile_scoreboard_counter.sv | 33 +++
 rtl/regfile_scoreboard.sv | 117 +++++++++++
 tb/tb_regfile_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file scoreboard slice.
// Sizes here are only defaults; instances may override them.
package regfile_scoreboard_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_NUM_RD_PORTS   = 2;
    localparam int DEF_PEND_CNT_WIDTH = 2;
    localparam int ZERO_REG           = 0;

    // A real, writable architectural register: not x0 and inside the file.
    function automatic logic isArchReg(input int addr, input int numRegs);
        return (addr != ZERO_REG) && (addr < numRegs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// Saturating outstanding-write counter for one register.
// Clear wins over claim/release; a simultaneous claim and release cancel out.
module regfile_scoreboard_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending-write counters,
// combinational read ports with optional write-back bypass, and decode stall.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int NUM_RD_PORTS   = DEF_NUM_RD_PORTS,
    parameter int PEND_CNT_WIDTH = DEF_PEND_CNT_WIDTH,
    parameter bit BYPASS_EN      = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 uop_valid,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_RD_PORTS-1:0]              rd_en,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]              rd_ready,
    input  logic                                 wb_en,
    input  logic [REG_ADDR_WIDTH-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]                wb_data,
    input  logic                                 claim_en,
    input  logic [REG_ADDR_WIDTH-1:0]            claim_addr,
    input  logic                                 flush,
    output logic                                 source_not_ready,
    output logic                                 claim_full,
    output logic                                 stall,
    output logic                                 pending_any
);

    localparam logic [PEND_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PEND_CNT_WIDTH-1:0] CNT_ONE = PEND_CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]     r_regs [NUM_REGS];
    logic [PEND_CNT_WIDTH-1:0] w_cnt  [NUM_REGS];
    logic [NUM_RD_PORTS-1:0]   w_srcReady;
    logic                      w_claimInRange;
    logic                      w_claimSat;
    logic                      w_wbRelease;
    logic                      w_claimFire;

    // Register array: x0 is only ever reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wb_en) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (int'(wb_addr) == r) begin
                    r_regs[r] <= wb_data;
                end
            end
        end
    end

    assign w_cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic w_inc;
        logic w_dec;
        assign w_inc = w_claimFire && (int'(claim_addr) == r);
        assign w_dec = wb_en && (int'(wb_addr) == r);
        regfile_scoreboard_counter #(
            .WIDTH (PEND_CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_inc   (w_inc),
            .i_dec   (w_dec),
            .i_clr   (flush),
            .o_count (w_cnt[r])
        );
    end

    // Bypass only when this write-back retires the last outstanding write.
    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [REG_ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0]     w_data;
        logic                      w_ready;
        assign w_addr = rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        always_comb begin
            w_data  = '0;
            w_ready = 1'b1;
            if (isArchReg(int'(w_addr), NUM_REGS)) begin
                if (BYPASS_EN && wb_en && (wb_addr == w_addr) && (w_cnt[w_addr] == CNT_ONE)) begin
                    w_data = wb_data;
                end else begin
                    w_data  = r_regs[w_addr];
                    w_ready = (w_cnt[w_addr] == '0);
                end
            end
        end
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign w_srcReady[k] = w_ready;
        assign rd_ready[k]   = !rd_en[k] || w_ready;
    end

    assign w_claimInRange   = isArchReg(int'(claim_addr), NUM_REGS);
    assign w_claimSat       = w_claimInRange && (w_cnt[claim_addr] == CNT_MAX);
    assign w_wbRelease      = wb_en && (wb_addr == claim_addr);
    assign source_not_ready = uop_valid && ((rd_en & ~w_srcReady) != '0);
    assign claim_full       = uop_valid && claim_en && w_claimSat && !w_wbRelease;
    assign stall            = source_not_ready || claim_full;
    assign w_claimFire      = uop_valid && claim_en && !stall && !flush && w_claimInRange;

    always_comb begin
        pending_any = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (w_cnt[r] != '0) begin
                pending_any = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share
// stimulus and are checked against an array/arithmetic model every cycle.
module tb_regfile_scoreboard;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  rdy;
        logic        snr;
        logic        cf;
        logic        st;
        logic        pa;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        uopValid;
    logic [9:0]  rdAddr;
    logic [1:0]  rdEn;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        claimEn;
    logic [4:0]  claimAddr;
    logic        flush;

    logic [63:0] rdData0, rdData1;
    logic [1:0]  rdReady0, rdReady1;
    logic        snr0, snr1, cf0, cf1, st0, st1, pa0, pa1;
    exp_t        act0, act1;

    logic [31:0] mReg [2][32];
    int          mCnt [2][32];
    logic        checkEn;
    int          nCompared;
    int          nMismatched;

    regfile_scoreboard #(.BYPASS_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .uop_valid(uopValid), .rd_addr(rdAddr), .rd_en(rdEn),
        .rd_data(rdData0), .rd_ready(rdReady0), .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
        .claim_en(claimEn), .claim_addr(claimAddr), .flush(flush), .source_not_ready(snr0),
        .claim_full(cf0), .stall(st0), .pending_any(pa0)
    );

    regfile_scoreboard #(.BYPASS_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .uop_valid(uopValid), .rd_addr(rdAddr), .rd_en(rdEn),
        .rd_data(rdData1), .rd_ready(rdReady1), .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
        .claim_en(claimEn), .claim_addr(claimAddr), .flush(flush), .source_not_ready(snr1),
        .claim_full(cf1), .stall(st1), .pending_any(pa1)
    );

    assign act0 = {rdData0, rdReady0, snr0, cf0, st0, pa0};
    assign act1 = {rdData1, rdReady1, snr1, cf1, st1, pa1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs of variant b (1 = bypassing) from model state and current inputs.
    function automatic exp_t modelOut(input int b);
        exp_t        e;
        int          a;
        logic [1:0]  srcOk;
        e     = '0;
        srcOk = 2'b11;
        for (int k = 0; k < 2; k++) begin
            a = int'(rdAddr[k*5 +: 5]);
            if (a != 0) begin
                if (b == 1 && wbEn && int'(wbAddr) == a && mCnt[b][a] == 1) begin
                    e.d[k*32 +: 32] = wbData;
                end else begin
                    e.d[k*32 +: 32] = mReg[b][a];
                    srcOk[k] = (mCnt[b][a] == 0);
                end
            end
        end
        e.rdy = ~rdEn | srcOk;
        e.snr = uopValid && ((rdEn & ~srcOk) != 2'b00);
        e.cf  = uopValid && claimEn && claimAddr != 5'd0 && mCnt[b][claimAddr] == 3
                && !(wbEn && wbAddr == claimAddr);
        e.st  = e.snr || e.cf;
        for (int r = 0; r < 32; r++) begin
            if (mCnt[b][r] != 0) e.pa = 1'b1;
        end
        return e;
    endfunction

    function automatic int nextCnt(input int b, input int r);
        exp_t e;
        int   n;
        e = modelOut(b);
        n = mCnt[b][r];
        if (uopValid && claimEn && !e.st && !flush && int'(claimAddr) == r) n = n + 1;
        if (wbEn && int'(wbAddr) == r) n = n - 1;
        if (n < 0) n = 0;
        if (n > 3) n = 3;
        return n;
    endfunction

    // Model state advances on the same edge as the DUTs.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!reset) begin
                for (int r = 0; r < 32; r++) begin
                    mCnt[b][r] <= 0;
                    mReg[b][r] <= 32'h0;
                end
            end else begin
                if (wbEn && wbAddr != 5'd0) mReg[b][wbAddr] <= wbData;
                for (int r = 1; r < 32; r++) begin
                    mCnt[b][r] <= flush ? 0 : nextCnt(b, r);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared = nCompared + 1;
        if (actual !== expected) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareAll(input int b, input exp_t act);
        exp_t e;
        e = modelOut(b);
        checkOutput(b == 1 ? "byp.rd_data"  : "nobyp.rd_data",  act.d, e.d);
        checkOutput(b == 1 ? "byp.rd_ready" : "nobyp.rd_ready", 64'(act.rdy), 64'(e.rdy));
        checkOutput(b == 1 ? "byp.snr"      : "nobyp.snr",      64'(act.snr), 64'(e.snr));
        checkOutput(b == 1 ? "byp.claim_full" : "nobyp.claim_full", 64'(act.cf), 64'(e.cf));
        checkOutput(b == 1 ? "byp.stall"    : "nobyp.stall",    64'(act.st), 64'(e.st));
        checkOutput(b == 1 ? "byp.pending"  : "nobyp.pending",  64'(act.pa), 64'(e.pa));
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            compareAll(0, act0);
            compareAll(1, act1);
        end
    end

    // Drive one cycle of inputs just after a rising edge, then let outputs settle.
    task automatic applyStimulus(input logic uv, input logic [1:0] re, input logic [4:0] a1,
                                 input logic [4:0] a0, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic ce, input logic [4:0] ca,
                                 input logic fl, input logic rst);
        @(posedge clk);
        #1;
        uopValid  = uv;
        rdEn      = re;
        rdAddr    = {a1, a0};
        wbEn      = we;
        wbAddr    = wa;
        wbData    = wd;
        claimEn   = ce;
        claimAddr = ca;
        flush     = fl;
        reset     = rst;
        #1;
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        checkEn = 1'b0;
        {uopValid, rdEn, rdAddr, wbEn, wbAddr, wbData, claimEn, claimAddr, flush} = '0;
        reset = 1'b0;

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkEn = 1'b1;

        // Out of reset: everything reads zero and ready.
        applyStimulus(1, 2'b11, 2, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.reset.rd_data", act1.d, 64'h0);
        checkOutput("lit.reset.rd_ready", 64'(act1.rdy), 64'h3);
        checkOutput("lit.reset.stall", 64'(act1.st), 64'h0);
        checkOutput("lit.reset.pending", 64'(act1.pa), 64'h0);

        // Claim x5, read it pending, then same-cycle write-back.
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 5, 0, 1);
        checkOutput("lit.claim5.stall", 64'(act1.st), 64'h0);
        applyStimulus(1, 2'b01, 0, 5, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.x5pend.snr", 64'(act1.snr), 64'h1);
        checkOutput("lit.x5pend.stall", 64'(act1.st), 64'h1);
        checkOutput("lit.x5pend.pending", 64'(act1.pa), 64'h1);
        applyStimulus(1, 2'b01, 0, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1);
        checkOutput("lit.byp.rd_data", 64'(act1.d[31:0]), 64'hDEADBEEF);
        checkOutput("lit.byp.rd_ready", 64'(act1.rdy), 64'h3);
        checkOutput("lit.byp.stall", 64'(act1.st), 64'h0);
        checkOutput("lit.nobyp.rd_ready", 64'(act0.rdy), 64'h2);
        checkOutput("lit.nobyp.stall", 64'(act0.st), 64'h1);
        applyStimulus(1, 2'b01, 0, 5, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.nobyp.next.rd_ready", 64'(act0.rdy), 64'h3);
        checkOutput("lit.nobyp.next.rd_data", 64'(act0.d[31:0]), 64'hDEADBEEF);

        // Saturate x7, then a claim blocked, then a claim accepted beside a release.
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 7, 0, 1);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 7, 0, 1);
        checkOutput("lit.x7full.claim_full", 64'(act1.cf), 64'h1);
        checkOutput("lit.x7full.stall", 64'(act1.st), 64'h1);
        applyStimulus(1, 2'b00, 0, 0, 1, 7, 32'h77, 1, 7, 0, 1);
        checkOutput("lit.x7release.claim_full", 64'(act1.cf), 64'h0);
        checkOutput("lit.x7release.stall", 64'(act1.st), 64'h0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 7, 0, 1);
        checkOutput("lit.x7still3.claim_full", 64'(act1.cf), 64'h1);

        // Two outstanding writes to x3 retire in order.
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        applyStimulus(1, 2'b01, 0, 3, 1, 3, 32'h11, 0, 0, 0, 1);
        checkOutput("lit.x3older.rd_ready", 64'(act1.rdy), 64'h2);
        checkOutput("lit.x3older.stall", 64'(act1.st), 64'h1);
        applyStimulus(1, 2'b01, 0, 3, 1, 3, 32'h22, 0, 0, 0, 1);
        checkOutput("lit.x3last.rd_data", 64'(act1.d[31:0]), 64'h22);
        checkOutput("lit.x3last.rd_ready", 64'(act1.rdy), 64'h3);
        checkOutput("lit.x3last.nobyp.rd_ready", 64'(act0.rdy), 64'h2);
        applyStimulus(1, 2'b10, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.x3port1.rd_data", 64'(act0.d[63:32]), 64'h22);

        // Flush drops all claims; a late write-back still lands.
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 4, 0, 1);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 6, 0, 1);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("lit.flush.pending_before", 64'(act1.pa), 64'h1);
        applyStimulus(1, 2'b01, 0, 4, 1, 4, 32'h55, 0, 0, 0, 1);
        checkOutput("lit.flush.pending_after", 64'(act1.pa), 64'h0);
        checkOutput("lit.latewb.rd_data_old", 64'(act1.d[31:0]), 64'h0);
        applyStimulus(1, 2'b01, 0, 4, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.latewb.rd_data", 64'(act1.d[31:0]), 64'h55);
        checkOutput("lit.latewb.pending", 64'(act1.pa), 64'h0);

        // x0 ignores writes and claims.
        applyStimulus(1, 2'b11, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 1);
        checkOutput("lit.x0.rd_ready", 64'(act1.rdy), 64'h3);
        checkOutput("lit.x0.stall", 64'(act1.st), 64'h0);
        applyStimulus(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.x0.rd_data", act1.d, 64'h0);
        checkOutput("lit.x0.pending", 64'(act1.pa), 64'h0);

        // Reset with x9 written and pending.
        applyStimulus(0, 2'b00, 0, 0, 1, 9, 32'h99, 0, 0, 0, 1);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 9, 0, 1);
        applyStimulus(1, 2'b01, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lit.x9pre.rd_ready", 64'(act1.rdy), 64'h2);
        checkOutput("lit.x9pre.pending", 64'(act1.pa), 64'h1);
        applyStimulus(1, 2'b01, 0, 9, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit.x9post.rd_data", 64'(act1.d[31:0]), 64'h0);
        checkOutput("lit.x9post.rd_ready", 64'(act1.rdy), 64'h3);
        checkOutput("lit.x9post.pending", 64'(act1.pa), 64'h0);

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
